// File: rtl/multi_lane_muladd_pkg.sv
// Shared types for the multi-lane multiply-accumulate unit.
// Controller state encoding, opcode bit positions and pipeline tags.
package multi_lane_muladd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_ACTIVE,
    ST_DRAIN
  } state_t;

  localparam int OP_SUB    = 0;
  localparam int OP_PREADD = 1;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/multi_lane_muladd_lane.sv
// One signed MAC lane: optional pre-add, registered product,
// accumulate, arithmetic shift and optional saturation on output.
module muladd_lane
  import multi_lane_muladd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 72,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [1:0]        op,
  input  logic [5:0]        shift,
  input  logic              sample,
  input  tag_t              tag,
  output logic [DATA_W-1:0] out0
);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DATA_W-1:0]   a;
  logic signed [DATA_W-1:0]   b;
  logic signed [2*DATA_W-1:0] p_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_nx;
  logic signed [ACC_W-1:0]    p_ext;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    shd;
  logic        [DATA_W-1:0]   res;

  assign a = in0;
  assign b = op[OP_PREADD] ? in0 + in1 : in1;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
    end else if (sample) begin
      p_q <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
    end
  end

  always_comb begin
    p_ext  = ACC_W'(p_q);
    base   = tag.first ? '0 : acc_q;
    acc_nx = op[OP_SUB] ? base - p_ext : base + p_ext;
    shd    = acc_nx >>> shift;
    res    = shd[DATA_W-1:0];
    if (SAT != 0) begin
      if (shd > SAT_MAX) begin
        res = SAT_MAX[DATA_W-1:0];
      end else if (shd < SAT_MIN) begin
        res = SAT_MIN[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      out0  <= '0;
    end else if (tag.v) begin
      acc_q <= acc_nx;
      if (tag.last) begin
        out0 <= res;
      end
    end
  end

endmodule

// File: rtl/multi_lane_muladd.sv
// Multi-lane signed multiply-accumulate unit with a shared run/done
// controller: delay, period-based accumulation and iteration count.
module multi_lane_muladd
  import multi_lane_muladd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 1,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 10,
  parameter int SAT    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  output logic                    done,
  input  logic [LANES*DATA_W-1:0] in0,
  input  logic [LANES*DATA_W-1:0] in1,
  output logic [LANES*DATA_W-1:0] out0,
  input  logic [1:0]              opcode,
  input  logic [CNT_W-1:0]        iterations,
  input  logic [CNT_W-1:0]        period,
  input  logic [5:0]              shift,
  input  logic [31:0]             delay0
);

  state_t state;
  state_t state_nx;

  logic [1:0]       op_q;
  logic [CNT_W-1:0] iter_q;
  logic [CNT_W-1:0] per_q;
  logic [5:0]       shift_q;
  logic [31:0]      dly_q;
  logic [31:0]      dcnt;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] icnt;
  logic             p_first;
  logic             p_last;
  logic             start;
  tag_t             tag_q;

  assign start   = (state == ST_IDLE) && run;
  assign p_first = (pcnt == '0);
  assign p_last  = (pcnt == per_q - CNT_W'(1));
  assign done    = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (run) state_nx = ST_DELAY;
      end
      ST_DELAY: begin
        if (dcnt == dly_q) begin
          state_nx = (iter_q == '0) ? ST_IDLE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (p_last && icnt == iter_q - CNT_W'(1)) begin
          state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Config snapshot; a zero period behaves as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      iter_q  <= '0;
      per_q   <= '0;
      shift_q <= '0;
      dly_q   <= '0;
    end else if (start) begin
      op_q    <= opcode;
      iter_q  <= iterations;
      per_q   <= (period == '0) ? CNT_W'(1) : period;
      shift_q <= shift;
      dly_q   <= delay0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt <= '0;
      pcnt <= '0;
      icnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            dcnt <= '0;
            pcnt <= '0;
            icnt <= '0;
          end
        end
        ST_DELAY: dcnt <= dcnt + 32'd1;
        ST_ACTIVE: begin
          if (p_last) begin
            pcnt <= '0;
            icnt <= icnt + CNT_W'(1);
          end else begin
            pcnt <= pcnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q.v     <= (state == ST_ACTIVE);
      tag_q.first <= p_first;
      tag_q.last  <= p_last;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    muladd_lane #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W),
      .SAT   (SAT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .in0   (in0[i*DATA_W +: DATA_W]),
      .in1   (in1[i*DATA_W +: DATA_W]),
      .op    (op_q),
      .shift (shift_q),
      .sample(state == ST_ACTIVE),
      .tag   (tag_q),
      .out0  (out0[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_multi_lane_muladd.sv
// Bench for multi_lane_muladd: saturating and truncating instances
// driven in parallel and compared cycle by cycle to a reference model.
module tb_multi_lane_muladd;

  localparam int DW = 16;
  localparam int LN = 4;
  localparam int AW = 40;
  localparam int CW = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic [1:0]       opcode;
  logic [CW-1:0]    iterations;
  logic [CW-1:0]    period;
  logic [5:0]       shift;
  logic [31:0]      delay0;
  logic [LN*DW-1:0] in0;
  logic [LN*DW-1:0] in1;
  logic [LN*DW-1:0] out_s;
  logic [LN*DW-1:0] out_t;
  logic             done_s;
  logic             done_t;

  int n_chk  = 0;
  int n_fail = 0;

  logic signed [DW-1:0] sa [LN][64];
  logic signed [DW-1:0] sb [LN][64];
  logic        [DW-1:0] exp_s [LN];
  logic        [DW-1:0] exp_t [LN];

  always #5 clk = ~clk;

  multi_lane_muladd #(
    .DATA_W(DW), .LANES(LN), .ACC_W(AW), .CNT_W(CW), .SAT(1)
  ) dut_s (
    .clk(clk), .rst(rst), .run(run), .done(done_s),
    .in0(in0), .in1(in1), .out0(out_s), .opcode(opcode),
    .iterations(iterations), .period(period), .shift(shift),
    .delay0(delay0)
  );

  multi_lane_muladd #(
    .DATA_W(DW), .LANES(LN), .ACC_W(AW), .CNT_W(CW), .SAT(0)
  ) dut_t (
    .clk(clk), .rst(rst), .run(run), .done(done_t),
    .in0(in0), .in1(in1), .out0(out_t), .opcode(opcode),
    .iterations(iterations), .period(period), .shift(shift),
    .delay0(delay0)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sum of products over one period, then shift and saturate/truncate.
  function automatic logic [DW-1:0] model(input int lane, input int t,
      input int pe, input logic [1:0] op, input int sh, input bit sat);
    longint acc = 0;
    longint a;
    longint b;
    logic signed [DW-1:0] w;
    for (int k = 0; k < pe; k++) begin
      a = longint'(sa[lane][t*pe+k]);
      w = op[1] ? sa[lane][t*pe+k] + sb[lane][t*pe+k]
                : sb[lane][t*pe+k];
      b = longint'(w);
      acc = op[0] ? acc - a * b : acc + a * b;
    end
    acc = acc >>> sh;
    if (sat) begin
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
    end
    return acc[DW-1:0];
  endfunction

  task automatic fill_rand();
    for (int l = 0; l < LN; l++) begin
      for (int j = 0; j < 64; j++) begin
        sa[l][j] = DW'($urandom);
        sb[l][j] = DW'($urandom);
      end
    end
  endtask

  task automatic drive_sample(input int j);
    for (int l = 0; l < LN; l++) begin
      if (j >= 0 && j < 64) begin
        in0[l*DW +: DW] = sa[l][j];
        in1[l*DW +: DW] = sb[l][j];
      end else begin
        in0[l*DW +: DW] = DW'($urandom);
        in1[l*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic check_outs(input string tag, input logic exp_done);
    for (int l = 0; l < LN; l++) begin
      chk($sformatf("%s_sat_l%0d", tag, l), 64'(out_s[l*DW +: DW]),
          64'(exp_s[l]));
      chk($sformatf("%s_trn_l%0d", tag, l), 64'(out_t[l*DW +: DW]),
          64'(exp_t[l]));
    end
    chk({tag, "_done_s"}, 64'(done_s), 64'(exp_done));
    chk({tag, "_done_t"}, 64'(done_t), 64'(exp_done));
  endtask

  // Called just after a rising edge with both DUTs idle.
  task automatic run_job(input int d, input int it, input int per,
      input logic [1:0] op, input int sh, input string name);
    int pe;
    int n;
    int last_e;
    int t;
    pe     = (per == 0) ? 1 : per;
    n      = it * pe;
    last_e = (it == 0) ? d + 1 : d + 2 + n;
    opcode     = op;
    iterations = CW'(it);
    period     = CW'(per);
    shift      = 6'(sh);
    delay0     = 32'(d);
    run        = 1'b1;
    drive_sample(-1);
    @(posedge clk);
    #1;
    opcode     = 2'($urandom);
    iterations = CW'($urandom);
    period     = CW'($urandom);
    shift      = 6'($urandom);
    delay0     = $urandom;
    for (int e = 1; e <= last_e + 1; e++) begin
      drive_sample(e - d - 2);
      @(posedge clk);
      #1;
      run = 1'b0;
      if (it > 0 && e >= d + 2 + pe && (e - d - 2) % pe == 0) begin
        t = (e - d - 2) / pe - 1;
        if (t < it) begin
          for (int l = 0; l < LN; l++) begin
            exp_s[l] = model(l, t, pe, op, sh, 1'b1);
            exp_t[l] = model(l, t, pe, op, sh, 1'b0);
          end
        end
      end
      check_outs($sformatf("%s_c%0d", name, e), e >= last_e);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; opcode = '0; iterations = '0;
    period = '0; shift = '0; delay0 = '0; in0 = '0; in1 = '0;
    for (int l = 0; l < LN; l++) begin
      exp_s[l] = '0;
      exp_t[l] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    fill_rand();
    sa[0][0] = 16'sd3; sb[0][0] = 16'sd4;
    run_job(0, 1, 1, 2'b00, 0, "basic");
    chk("basic_12", 64'(out_t[DW-1:0]), 64'd12);

    run_job(0, 1, 1, 2'b10, 0, "preadd");
    chk("preadd_21", 64'(out_s[DW-1:0]), 64'd21);

    fill_rand();
    for (int j = 0; j < 8; j++) begin
      sa[0][j] = 16'(j + 1);
      sb[0][j] = 16'sd2;
    end
    run_job(0, 2, 4, 2'b01, 0, "period");
    chk("period_m52", 64'(out_t[DW-1:0]), 64'h0000_0000_0000_ffcc);

    fill_rand();
    sa[0][0] = 16'sh7fff; sb[0][0] = 16'sh7fff;
    run_job(0, 1, 1, 2'b00, 0, "sat0");
    chk("sat0_7fff", 64'(out_s[DW-1:0]), 64'h7fff);
    chk("trn0_0001", 64'(out_t[DW-1:0]), 64'h0001);
    run_job(0, 1, 1, 2'b00, 15, "sat15");
    chk("sat15_7ffe", 64'(out_s[DW-1:0]), 64'h7ffe);

    fill_rand();
    run_job(5, 2, 3, 2'b00, 4, "lanes_d5");
    run_job(2, 0, 3, 2'b00, 0, "iter0");
    run_job(1, 3, 0, 2'b01, 2, "per0");
    run_job(0, 2, 2, 2'b10, 50, "bigshift");

    for (int r = 0; r < 8; r++) begin
      fill_rand();
      run_job($urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), 2'($urandom),
              $urandom_range(0, 63), $sformatf("rnd%0d", r));
    end

    fill_rand();
    opcode = 2'b00; iterations = CW'(3); period = CW'(4);
    shift = '0; delay0 = '0; run = 1'b1;
    drive_sample(0);
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_done_s", 64'(done_s), 64'd0);
    rst = 1'b1;
    run = 1'b1;
    @(posedge clk);
    #1;
    for (int l = 0; l < LN; l++) begin
      exp_s[l] = '0;
      exp_t[l] = '0;
    end
    check_outs("midrst", 1'b1);
    rst = 1'b0;
    run = 1'b0;
    @(posedge clk);
    #1;
    check_outs("postrst", 1'b1);

    fill_rand();
    run_job(1, 2, 2, 2'b00, 3, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
